c7bexu_bypnet: RTL

Parametrised operand-bypass and interlock network for the c7bexu execute stage. It has NRP read ports instead of two and forwards from M, W and HOLD internal post-writeback stages. The HOLD stages cover the register-file write-to-read gap without regfile write-through. It also detects load-use hazards, raises a stall, and keeps saturating stall-cycle statistics. It sits between the D/E operand registers and the ALU operand inputs.

---
 rtl/c7bexu_pkg.sv | 18 +
 rtl/c7bexu_bypnet_if.sv | 37 +++
 rtl/c7bexu_bypsel.sv | 68 ++++++
 rtl/c7bexu_bypnet.sv | 122 ++++++++++++
 4 files changed

// File: rtl/c7bexu_pkg.sv
// Shared constants and types for the c7bexu execute-stage operand bypass network.
package c7bexu_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  localparam logic [1:0] BYP_RF = 2'd0;
  localparam logic [1:0] BYP_M  = 2'd1;
  localparam logic [1:0] BYP_W  = 2'd2;
  localparam logic [1:0] BYP_H  = 2'd3;

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } hold_ent_t;

endpackage

// File: rtl/c7bexu_bypnet_if.sv
// Operand/producer bus between the D/E operand registers, the bypass network and the ALU.
interface c7bexu_bypnet_if #(
  parameter int NRP  = 2,
  parameter int XLEN = 32,
  parameter int CNTW = 16
);

  logic [NRP*c7bexu_pkg::REG_AW-1:0] rs_e;
  logic [NRP-1:0]                    rs_ren_e;
  logic [NRP*XLEN-1:0]               rf_data_e;
  logic [c7bexu_pkg::REG_AW-1:0]     rd_m;
  logic                              wen_m;
  logic [XLEN-1:0]                   rd_data_m;
  logic                              vld_m;
  logic [c7bexu_pkg::REG_AW-1:0]     rd_w;
  logic                              wen_w;
  logic [XLEN-1:0]                   rd_data_w;
  logic                              cnt_clr;
  logic [NRP*XLEN-1:0]               rs_data_byp_e;
  logic [NRP*2-1:0]                  byp_src_e;
  logic                              stall_e;
  logic [CNTW-1:0]                   stall_cnt;
  logic                              stall_long;

  modport master (
    output rs_e, rs_ren_e, rf_data_e, rd_m, wen_m, rd_data_m, vld_m,
           rd_w, wen_w, rd_data_w, cnt_clr,
    input  rs_data_byp_e, byp_src_e, stall_e, stall_cnt, stall_long
  );

  modport slave (
    input  rs_e, rs_ren_e, rf_data_e, rd_m, wen_m, rd_data_m, vld_m,
           rd_w, wen_w, rd_data_w, cnt_clr,
    output rs_data_byp_e, byp_src_e, stall_e, stall_cnt, stall_long
  );

endinterface

// File: rtl/c7bexu_bypsel.sv
// Per-read-port source selection: one-hot select {Hk.., W, M, RF}, encoded source and load-use hit.
module c7bexu_bypsel
  import c7bexu_pkg::*;
#(
  parameter int  HOLD   = 1,
  localparam int HOLD_N = (HOLD > 0) ? HOLD : 1,
  localparam int NSRC   = 3 + HOLD_N
) (
  input  logic [REG_AW-1:0]        rs,
  input  logic                     ren,
  input  logic                     wen_m,
  input  logic [REG_AW-1:0]        rd_m,
  input  logic                     vld_m,
  input  logic                     wen_w,
  input  logic [REG_AW-1:0]        rd_w,
  input  logic [HOLD_N-1:0]        hold_vld,
  input  logic [HOLD_N*REG_AW-1:0] hold_rd,
  output logic [NSRC-1:0]          sel,
  output logic [1:0]               byp_src,
  output logic                     lu_hit
);

  logic              rs_nz;
  logic              hit_m;
  logic              hit_w;
  logic [HOLD_N-1:0] hit_h;
  logic [HOLD_N-1:0] sel_h;

  // x0 and non-reading ports never forward
  assign rs_nz = ren && (rs != '0);
  assign hit_m = rs_nz && wen_m && (rd_m == rs);
  assign hit_w = rs_nz && wen_w && (rd_w == rs);

  always_comb begin
    hit_h = '0;
    for (int k = 0; k < HOLD_N; k++) begin
      hit_h[k] = (HOLD > 0) && rs_nz && hold_vld[k] && (hold_rd[k*REG_AW +: REG_AW] == rs);
    end
  end

  // youngest hold stage wins on duplicate destinations
  always_comb begin
    sel_h = '0;
    for (int k = HOLD_N - 1; k >= 0; k--) begin
      if (hit_h[k]) sel_h = HOLD_N'(1) << k;
    end
  end

  always_comb begin
    sel     = '0;
    byp_src = BYP_RF;
    if (hit_m) begin
      sel[1]  = 1'b1;
      byp_src = BYP_M;
    end else if (hit_w) begin
      sel[2]  = 1'b1;
      byp_src = BYP_W;
    end else if (|hit_h) begin
      sel[NSRC-1:3] = sel_h;
      byp_src       = BYP_H;
    end else begin
      sel[0] = 1'b1;
    end
  end

  assign lu_hit = hit_m && !vld_m;

endmodule

// File: rtl/c7bexu_bypnet.sv
// Operand bypass and load-use interlock for the c7bexu execute stage, with post-W hold
// stages covering the regfile write-to-read gap and saturating stall statistics.
module c7bexu_bypnet #(
  parameter int XLEN  = c7bexu_pkg::XLEN,
  parameter int NRP   = 2,
  parameter int HOLD  = 1,
  parameter int CNTW  = 16,
  parameter int LONGW = 4
) (
  input logic             clk,
  input logic             resetn,
  c7bexu_bypnet_if.slave  bus
);

  import c7bexu_pkg::*;

  localparam int HOLD_N = (HOLD > 0) ? HOLD : 1;
  localparam int NSRC   = 3 + HOLD_N;
  localparam logic [CNTW-1:0]  CNT_MAX = '1;
  localparam logic [LONGW-1:0] RUN_MAX = '1;

  logic [HOLD_N-1:0]             h_vld;
  logic [HOLD_N-1:0][REG_AW-1:0] h_rd;
  logic [HOLD_N-1:0][XLEN-1:0]   h_data;

  logic [NRP-1:0][NSRC-1:0] sel;
  logic [NRP-1:0][1:0]      byp_src;
  logic [NRP-1:0][XLEN-1:0] byp_data;
  logic [NRP-1:0]           lu_hit;
  logic                     stall;

  logic [CNTW-1:0]  stall_cnt_q;
  logic [LONGW-1:0] run_q;
  logic [LONGW-1:0] run_nxt;
  logic             stall_long_q;

  // W always retires, so the hold pipe shifts every cycle regardless of stall
  if (HOLD > 0) begin : g_hold
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        h_vld  <= '0;
        h_rd   <= '0;
        h_data <= '0;
      end else begin
        h_vld[0]  <= bus.wen_w;
        h_rd[0]   <= bus.rd_w;
        h_data[0] <= bus.rd_data_w;
        for (int k = 1; k < HOLD_N; k++) begin
          h_vld[k]  <= h_vld[k-1];
          h_rd[k]   <= h_rd[k-1];
          h_data[k] <= h_data[k-1];
        end
      end
    end
  end else begin : g_nohold
    assign h_vld  = '0;
    assign h_rd   = '0;
    assign h_data = '0;
  end

  for (genvar p = 0; p < NRP; p++) begin : g_port
    c7bexu_bypsel #(
      .HOLD (HOLD)
    ) u_bypsel (
      .rs       (bus.rs_e[p*REG_AW +: REG_AW]),
      .ren      (bus.rs_ren_e[p]),
      .wen_m    (bus.wen_m),
      .rd_m     (bus.rd_m),
      .vld_m    (bus.vld_m),
      .wen_w    (bus.wen_w),
      .rd_w     (bus.rd_w),
      .hold_vld (h_vld),
      .hold_rd  (h_rd),
      .sel      (sel[p]),
      .byp_src  (byp_src[p]),
      .lu_hit   (lu_hit[p])
    );
  end

  // AND-OR mux on the one-hot select
  always_comb begin
    byp_data = '0;
    for (int p = 0; p < NRP; p++) begin
      byp_data[p] = (bus.rf_data_e[p*XLEN +: XLEN] & {XLEN{sel[p][0]}})
                  | (bus.rd_data_m & {XLEN{sel[p][1]}})
                  | (bus.rd_data_w & {XLEN{sel[p][2]}});
      for (int k = 0; k < HOLD_N; k++) begin
        byp_data[p] = byp_data[p] | (h_data[k] & {XLEN{sel[p][3+k]}});
      end
    end
  end

  assign stall = |lu_hit;

  always_comb begin
    run_nxt = '0;
    if (stall) run_nxt = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q  <= '0;
      run_q        <= '0;
      stall_long_q <= 1'b0;
    end else begin
      if (bus.cnt_clr) begin
        stall_cnt_q <= '0;
      end else if (stall && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      run_q        <= run_nxt;
      stall_long_q <= (run_nxt == RUN_MAX);
    end
  end

  assign bus.rs_data_byp_e = byp_data;
  assign bus.byp_src_e     = byp_src;
  assign bus.stall_e       = stall;
  assign bus.stall_cnt     = stall_cnt_q;
  assign bus.stall_long    = stall_long_q;

endmodule
